// File: rtl/seg6_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg6_scan_ctrl
//
// Time-multiplexed scan controller for a six-digit common-anode
// seven-segment display.
//
// A six-digit BCD word is written through a valid/ready port into a staging
// register. The staged word moves into the display register only at a frame
// boundary, which is the end of digit 5's slot. Because of this, a digit never
// shows a mix of old and new data.
//
// Each digit slot lasts REFRESH_DIV clocks. The first BLANK_CYCLES of each
// slot drive all anodes off to stop ghosting between digits. Leading-zero
// blanking and per-digit decimal points are supported.
//
// Every pin-facing output is registered. Each one reflects the
// prescaler/index state of the previous cycle.
//
// Parameters:
//   REFRESH_DIV   clocks per digit slot (>= BLANK_CYCLES + 2)
//   BLANK_CYCLES  dead cycles at the start of each slot
//   CNT_W         prescaler width (2**CNT_W >= REFRESH_DIV)
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      1 = scanning; 0 = dark, prescaler/index frozen
//   wr_valid    write request
//   wr_data     six BCD nibbles, [3:0] = digit 0 (rightmost)
//   wr_dp       decimal-point request per digit, 1 = lit
//   wr_ready    staging register free
//   blank_lz    1 = suppress leading zeros
//   seg         active-low segments, gfe_dcba
//   dp          active-low decimal point
//   an          active-low anodes, an[i] drives digit i
//   frame_done  one-cycle pulse after digit 5's slot ends
// ---------------------------------------------------------------------------
module seg6_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        wr_valid,
    input  logic [23:0] wr_data,
    input  logic [5:0]  wr_dp,
    output logic        wr_ready,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_LIT  = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    // Scan position
    logic [CNT_W-1:0] presc;
    logic [2:0]       idx;

    // Word currently on display
    logic [23:0]      disp_data;
    logic [5:0]       disp_dp;

    // Staging register. It is full whenever wr_ready is low.
    logic [23:0]      stage_data;
    logic [5:0]       stage_dp;

    // Per-cycle decisions
    logic             slot_end;
    logic             frame_wrap;
    logic             accept;
    logic             commit;

    // Selected digit
    logic [3:0]       cur_nib;
    logic             cur_dp;
    logic             cur_lz;
    logic [5:0]       an_sel;
    logic [5:0]       lz_blank;
    logic             zero_run;

    // BCD to active-low segments, gfe_dcba. Non-BCD nibbles are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot_end   = (presc == PRESC_LAST);
    assign frame_wrap = enable & slot_end & (idx == 3'd5);
    assign accept     = wr_valid & wr_ready;

    // A commit only happens when the staging register holds data. While
    // staging is full wr_ready is 0, so accept and commit can never fire
    // together. A write that lands on a boundary while staging is empty is
    // simply captured, and it waits for the next boundary.
    assign commit     = frame_wrap & ~wr_ready;

    // Leading-zero mask. Scan down from digit 5. A digit is blanked while it
    // and every digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        lz_blank = 6'b000000;
        zero_run = blank_lz;
        for (int i = 5; i >= 1; i--) begin
            zero_run    = zero_run & (disp_data[i*4 +: 4] == 4'd0);
            lz_blank[i] = zero_run;
        end
    end

    // Select the nibble, decimal point, blank flag and anode for the
    // current index.
    always_comb begin
        cur_nib = disp_data[3:0];
        cur_dp  = disp_dp[0];
        cur_lz  = lz_blank[0];
        an_sel  = 6'b111110;
        case (idx)
            3'd1: begin
                cur_nib = disp_data[7:4];
                cur_dp  = disp_dp[1];
                cur_lz  = lz_blank[1];
                an_sel  = 6'b111101;
            end
            3'd2: begin
                cur_nib = disp_data[11:8];
                cur_dp  = disp_dp[2];
                cur_lz  = lz_blank[2];
                an_sel  = 6'b111011;
            end
            3'd3: begin
                cur_nib = disp_data[15:12];
                cur_dp  = disp_dp[3];
                cur_lz  = lz_blank[3];
                an_sel  = 6'b110111;
            end
            3'd4: begin
                cur_nib = disp_data[19:16];
                cur_dp  = disp_dp[4];
                cur_lz  = lz_blank[4];
                an_sel  = 6'b101111;
            end
            3'd5: begin
                cur_nib = disp_data[23:20];
                cur_dp  = disp_dp[5];
                cur_lz  = lz_blank[5];
                an_sel  = 6'b011111;
            end
            default: begin
                cur_nib = disp_data[3:0];
                cur_dp  = disp_dp[0];
                cur_lz  = lz_blank[0];
                an_sel  = 6'b111110;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= 3'd0;
            disp_data  <= 24'd0;
            disp_dp    <= 6'd0;
            stage_data <= 24'd0;
            stage_dp   <= 6'd0;
            wr_ready   <= 1'b1;
            frame_done <= 1'b0;
            an         <= 6'b111111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            frame_done <= frame_wrap;

            if (enable) begin
                if (slot_end) begin
                    presc <= '0;
                    idx   <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
                end else begin
                    presc <= presc + PRESC_ONE;
                end
            end

            if (commit) begin
                disp_data <= stage_data;
                disp_dp   <= stage_dp;
            end

            if (accept) begin
                stage_data <= wr_data;
                stage_dp   <= wr_dp;
            end

            if (accept) begin
                wr_ready <= 1'b0;
            end else if (commit) begin
                wr_ready <= 1'b1;
            end

            // The outputs are built from this cycle's prescaler/index. They
            // appear one clock later.
            if (!enable || (presc < PRESC_LIT)) begin
                an  <= 6'b111111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= an_sel;
                seg <= cur_lz ? 7'b1111111 : seg_decode(cur_nib);
                dp  <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seg6_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg6_scan_ctrl
//
// Directed bench for seg6_scan_ctrl, configured with REFRESH_DIV=4 and
// BLANK_CYCLES=1, so each slot is one dead cycle followed by three lit
// cycles.
//
// The stimulus pushes one expected entry per lit slot: anode pattern,
// segments, decimal point and expected lit length. A monitor opens a new
// entry at the start of each lit run, compares every lit cycle against it,
// and checks the run length when the run ends.
// ---------------------------------------------------------------------------
module tb_seg6_scan_ctrl;

    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int CNT_W        = 4;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S6  = 7'b0000010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] S9  = 7'b0011000;
    localparam logic [6:0] SBL = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        wr_valid;
    logic [23:0] wr_data;
    logic [5:0]  wr_dp;
    logic        wr_ready;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] len;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor state
    bit   in_run;
    bit   cur_valid;
    int   run_len;
    exp_t cur;

    always #5 clk = ~clk;

    seg6_scan_ctrl #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_ready   (wr_ready),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_slot(input int i, input logic [6:0] s, input logic dpreq, input int len);
        exp_t       e;
        logic [5:0] one;
        one   = 6'b000001;
        e.an  = ~(one << i);
        e.seg = s;
        e.dp  = ~dpreq;
        e.len = 4'(len);
        sb.push_back(e);
    endtask

    // Segment arguments are in display order, digit 5 first.
    task automatic push_frame(input logic [6:0] s5, input logic [6:0] s4, input logic [6:0] s3,
                              input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0,
                              input logic [5:0] dpreq);
        push_slot(0, s0, dpreq[0], 3);
        push_slot(1, s1, dpreq[1], 3);
        push_slot(2, s2, dpreq[2], 3);
        push_slot(3, s3, dpreq[3], 3);
        push_slot(4, s4, dpreq[4], 3);
        push_slot(5, s5, dpreq[5], 3);
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no frame_done within 200 cycles at %0t", $time);
        end
    endtask

    task automatic write(input logic [23:0] d, input logic [5:0] p, input string name);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = p;
        @(negedge clk);
        check(name, wr_ready, 1'b0);
        wr_valid = 1'b0;
    endtask

    // Scoreboard monitor
    initial begin
        in_run    = 1'b0;
        cur_valid = 1'b0;
        run_len   = 0;
        forever begin
            @(negedge clk);
            if (an != 6'b111111) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 0;
                    if (sb.size() > 0) begin
                        cur       = sb.pop_front();
                        cur_valid = 1'b1;
                    end else begin
                        cur_valid = 1'b0;
                    end
                end
                run_len++;
                if (cur_valid) begin
                    check("scan_an", an, cur.an);
                    check("scan_seg", seg, cur.seg);
                    check("scan_dp", dp, cur.dp);
                end
            end else begin
                if (in_run && cur_valid && cur.len != 4'd0)
                    check("lit_len", run_len, cur.len);
                in_run    = 1'b0;
                cur_valid = 1'b0;
            end
        end
    end

    initial begin
        int  fd_at;
        bit  early;
        bit  found;
        int  lit_cnt;
        int  fd_cnt;

        reset    = 1'b1;
        enable   = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 24'd0;
        wr_dp    = 6'd0;
        blank_lz = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an", an, 6'b111111);
        check("rst_seg", seg, 7'b1111111);
        check("rst_dp", dp, 1'b1);
        check("rst_ready", wr_ready, 1'b1);
        check("rst_fd", frame_done, 1'b0);
        reset = 1'b0;
        push_frame(S0, S0, S0, S0, S0, S0, 6'b000000);

        fd_at = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                fd_at = k;
                break;
            end
        end
        check("first_frame_done", fd_at, 24);

        // Scan order. The display keeps showing zeros until the boundary.
        push_frame(S0, S0, S0, S0, S0, S0, 6'b000000);
        write(24'h123456, 6'b000100, "accept_123456");
        wait_frame();
        check("ready_after_commit", wr_ready, 1'b1);
        push_frame(S1, S2, S3, S4, S5, S6, 6'b000100);

        // Leading zeros
        write(24'h000070, 6'b000000, "accept_000070");
        wait_frame();
        blank_lz = 1'b1;
        push_frame(SBL, SBL, SBL, SBL, S7, S0, 6'b000000);
        wait_frame();
        blank_lz = 1'b0;
        push_frame(S0, S0, S0, S0, S7, S0, 6'b000000);

        // Write A mid-frame, then hold B until the staging register frees up.
        repeat (5) @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 24'h654321;
        wr_dp    = 6'b000000;
        @(negedge clk);
        check("accept_a", wr_ready, 1'b0);
        wr_data = 24'h987650;
        wr_dp   = 6'b100001;
        early   = 1'b0;
        found   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (wr_ready !== 1'b0) early = 1'b1;
        end
        check("b_held_off", early, 1'b0);
        check("boundary_seen", found, 1'b1);
        check("ready_at_boundary", wr_ready, 1'b1);
        push_frame(S6, S5, S4, S3, S2, S1, 6'b000000);
        @(negedge clk);
        check("accept_b", wr_ready, 1'b0);
        wr_valid = 1'b0;
        wait_frame();
        check("ready_after_b", wr_ready, 1'b1);
        push_frame(S9, S8, S7, S6, S5, S0, 6'b100001);

        // Invalid nibbles, with enable dropped in slot 3
        write(24'hF0000A, 6'b100001, "accept_f0000a");
        wait_frame();
        blank_lz = 1'b1;
        push_slot(0, SBL, 1'b1, 3);
        push_slot(1, S0, 1'b0, 3);
        push_slot(2, S0, 1'b0, 3);
        push_slot(3, S0, 1'b0, 1);
        push_slot(3, S0, 1'b0, 2);
        push_slot(4, S0, 1'b0, 3);
        push_slot(5, SBL, 1'b1, 3);
        repeat (14) @(negedge clk);
        check("slot3_lit", an, 6'b110111);
        enable  = 1'b0;
        lit_cnt = 0;
        fd_cnt  = 0;
        repeat (10) begin
            @(negedge clk);
            if (an != 6'b111111) lit_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
        check("disabled_dark", lit_cnt, 0);
        check("disabled_no_fd", fd_cnt, 0);
        enable = 1'b1;
        wait_frame();

        // Reset while the staging register is full
        write(24'h222222, 6'b000000, "accept_222222");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", wr_ready, 1'b1);
        check("midrst_an", an, 6'b111111);
        check("midrst_seg", seg, 7'b1111111);
        check("midrst_dp", dp, 1'b1);
        check("midrst_fd", frame_done, 1'b0);
        reset    = 1'b0;
        blank_lz = 1'b0;
        push_frame(S0, S0, S0, S0, S0, S0, 6'b000000);
        push_frame(S0, S0, S0, S0, S0, S0, 6'b000000);
        wait_frame();
        check("midrst_ready_frame1", wr_ready, 1'b1);
        wait_frame();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
